// File: rtl/mig_app_pkg.sv
// Shared constants and helpers for the MIG app-port responder.
package mig_app_pkg;

    localparam int APP_ADDR_W = 28;
    localparam int APP_DATA_W = 128;
    localparam int APP_MASK_W = 16;
    localparam int WDF_DEPTH  = 4;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    // One step of the 16-bit Fibonacci stall LFSR (taps 16,14,13,11).
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

endpackage

// File: rtl/mig_wdf_fifo.sv
// Four-entry write-data FIFO (data + byte mask) with registered occupancy.
// full_next exposes the post-edge fullness so the parent can register its ready.
module mig_wdf_fifo
    import mig_app_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [APP_DATA_W-1:0] push_data,
    input  logic [APP_MASK_W-1:0] push_mask,
    input  logic                  pop,
    output logic [APP_DATA_W-1:0] head_data,
    output logic [APP_MASK_W-1:0] head_mask,
    output logic                  empty,
    output logic                  full,
    output logic                  full_next
);

    logic [APP_DATA_W-1:0] data_r [WDF_DEPTH];
    logic [APP_MASK_W-1:0] mask_r [WDF_DEPTH];
    logic [1:0]            wr_ptr_r;
    logic [1:0]            rd_ptr_r;
    logic [2:0]            count_r;
    logic [2:0]            count_next_s;
    logic                  push_s;
    logic                  pop_s;

    assign empty     = (count_r == 3'd0);
    assign full      = (count_r == 3'd4);
    assign push_s    = push & ~full;
    assign pop_s     = pop & ~empty;
    assign head_data = data_r[rd_ptr_r];
    assign head_mask = mask_r[rd_ptr_r];
    assign full_next = (count_next_s == 3'd4);

    // Occupancy after the current edge's push/pop.
    always_comb begin
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + 3'd1;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - 3'd1;
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            count_r <= count_next_s;
        end
    end

    // Payload storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_r[wr_ptr_r] <= push_data;
            mask_r[wr_ptr_r] <= push_mask;
        end
    end

endmodule

// File: rtl/mig_app_responder.sv
// Block-RAM stand-in for the DDR3 controller app port: serialised write/read
// commands, fixed read latency and LFSR-driven backpressure on both readies.
module mig_app_responder
    import mig_app_pkg::*;
#(
    parameter int          ADDR_BITS    = 10,
    parameter int          READ_LATENCY = 4,
    parameter int          CALIB_CYCLES = 64,
    parameter int          STALL_ENABLE = 1,
    parameter logic [15:0] STALL_SEED   = 16'hace1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [APP_ADDR_W-1:0] app_addr,
    input  logic [2:0]            app_cmd,
    input  logic                  app_en,
    output logic                  app_rdy,
    input  logic [APP_DATA_W-1:0] app_wdf_data,
    input  logic [APP_MASK_W-1:0] app_wdf_mask,
    input  logic                  app_wdf_wren,
    input  logic                  app_wdf_end,
    output logic                  app_wdf_rdy,
    output logic [APP_DATA_W-1:0] app_rd_data,
    output logic                  app_rd_data_valid,
    output logic                  init_calib_complete,
    output logic                  error
);

    localparam int                 CALIB_W    = $clog2(CALIB_CYCLES + 1);
    localparam logic [CALIB_W-1:0] CALIB_LAST = CALIB_W'(CALIB_CYCLES - 1);
    localparam logic               STALL_ON   = (STALL_ENABLE != 0);
    localparam int                 MEM_DEPTH  = 1 << ADDR_BITS;

    logic [APP_DATA_W-1:0] mem_r [MEM_DEPTH];
    logic [APP_DATA_W-1:0] rd_pipe_r [READ_LATENCY];
    logic [READ_LATENCY-1:0] vld_pipe_r;

    logic [CALIB_W-1:0]    calib_cnt_r;
    logic                  calib_r;
    logic [15:0]           lfsr_r;
    logic                  pending_r;
    logic [ADDR_BITS-1:0]  pending_addr_r;
    logic                  app_rdy_r;
    logic                  wdf_rdy_r;
    logic                  error_r;
    logic [APP_DATA_W-1:0] rd_data_r;
    logic                  rd_valid_r;

    logic                  calib_next_s;
    logic [15:0]           lfsr_next_s;
    logic                  cmd_acc_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic                  bad_cmd_s;
    logic [ADDR_BITS-1:0]  word_idx_s;
    logic                  commit_s;
    logic [ADDR_BITS-1:0]  commit_addr_s;
    logic                  pending_next_s;
    logic                  push_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic                  fifo_full_next_s;
    logic [APP_DATA_W-1:0] fifo_head_data_s;
    logic [APP_MASK_W-1:0] fifo_head_mask_s;
    logic                  proto_err_s;
    logic                  addr_unused_s;

    assign word_idx_s    = app_addr[ADDR_BITS+2:3];
    assign addr_unused_s = ^{app_addr[APP_ADDR_W-1:ADDR_BITS+3], app_addr[2:0], fifo_full_s};

    // Command decode: ready-qualified; unknown opcodes are flagged and dropped.
    assign cmd_acc_s = app_en & app_rdy_r;
    assign wr_acc_s  = cmd_acc_s & (app_cmd == CMD_WRITE);
    assign rd_acc_s  = cmd_acc_s & (app_cmd == CMD_READ);
    assign bad_cmd_s = cmd_acc_s & ~wr_acc_s & ~rd_acc_s;
    assign push_s    = app_wdf_wren & wdf_rdy_r;

    // A write (new or held) commits as soon as data is at the FIFO head.
    assign commit_s       = (wr_acc_s | pending_r) & ~fifo_empty_s;
    assign commit_addr_s  = pending_r ? pending_addr_r : word_idx_s;
    assign pending_next_s = (wr_acc_s | pending_r) & fifo_empty_s;

    assign calib_next_s = calib_r | (calib_cnt_r == CALIB_LAST);
    assign lfsr_next_s  = calib_r ? lfsr_step(lfsr_r) : lfsr_r;
    assign proto_err_s  = bad_cmd_s | (app_wdf_wren ^ app_wdf_end);

    mig_wdf_fifo u_wdf_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (app_wdf_data),
        .push_mask (app_wdf_mask),
        .pop       (commit_s),
        .head_data (fifo_head_data_s),
        .head_mask (fifo_head_mask_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .full_next (fifo_full_next_s)
    );

    // Calibration delay after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            calib_cnt_r <= '0;
            calib_r     <= 1'b0;
        end else if (!calib_r) begin
            calib_cnt_r <= calib_cnt_r + CALIB_W'(1);
            calib_r     <= calib_next_s;
        end else begin
            calib_r     <= 1'b1;
        end
    end

    // Stall LFSR, pending write, error flag and the two readies, each ready
    // registered from next-state values so it equals its rule in every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_r         <= STALL_SEED;
            pending_r      <= 1'b0;
            pending_addr_r <= '0;
            app_rdy_r      <= 1'b0;
            wdf_rdy_r      <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            lfsr_r    <= lfsr_next_s;
            pending_r <= pending_next_s;
            if (wr_acc_s) begin
                pending_addr_r <= word_idx_s;
            end
            app_rdy_r <= calib_next_s & ~pending_next_s
                         & ~(STALL_ON & lfsr_next_s[0] & lfsr_next_s[1]);
            wdf_rdy_r <= calib_next_s & ~fifo_full_next_s
                         & ~(STALL_ON & lfsr_next_s[2] & lfsr_next_s[3]);
            error_r   <= error_r | proto_err_s;
        end
    end

    // Read valid pipeline and registered read-data outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe_r <= '0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            vld_pipe_r <= {vld_pipe_r[READ_LATENCY-2:0], rd_acc_s};
            rd_valid_r <= vld_pipe_r[READ_LATENCY-1];
            if (vld_pipe_r[READ_LATENCY-1]) begin
                rd_data_r <= rd_pipe_r[READ_LATENCY-1];
            end
        end
    end

    // Block RAM: masked byte commits, stage-1 synchronous read, data shift.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            for (int b = 0; b < APP_MASK_W; b++) begin
                if (!fifo_head_mask_s[b]) begin
                    mem_r[commit_addr_s][b*8 +: 8] <= fifo_head_data_s[b*8 +: 8];
                end
            end
        end
        if (rd_acc_s) begin
            rd_pipe_r[0] <= mem_r[word_idx_s];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_pipe_r[i] <= rd_pipe_r[i-1];
        end
    end

    assign app_rdy             = app_rdy_r;
    assign app_wdf_rdy         = wdf_rdy_r;
    assign app_rd_data         = rd_data_r;
    assign app_rd_data_valid   = rd_valid_r;
    assign init_calib_complete = calib_r;
    assign error               = error_r;

endmodule

// File: tb/tb_mig_app_responder.sv
// Self-checking bench for mig_app_responder: handshake-driven stimulus and a
// plain word-array memory model with byte-mask merge.
module tb_mig_app_responder;

    localparam logic [2:0] WR = 3'b000;
    localparam logic [2:0] RD = 3'b001;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [27:0]  app_addr = 28'd0;
    logic [2:0]   app_cmd = 3'd0;
    logic         app_en = 1'b0;
    logic         app_rdy;
    logic [127:0] app_wdf_data = 128'd0;
    logic [15:0]  app_wdf_mask = 16'd0;
    logic         app_wdf_wren = 1'b0;
    logic         app_wdf_end = 1'b0;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         init_calib_complete;
    logic         error;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [127:0] ref_mem [0:1023];

    mig_app_responder #(
        .ADDR_BITS(10), .READ_LATENCY(4), .CALIB_CYCLES(64),
        .STALL_ENABLE(1), .STALL_SEED(16'hace1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .app_addr(app_addr), .app_cmd(app_cmd),
        .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .init_calib_complete(init_calib_complete), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached after %0d tests", tests);
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] merge(input logic [127:0] old_w,
                                           input logic [127:0] new_w,
                                           input logic [15:0] m);
        logic [127:0] r = old_w;
        for (int b = 0; b < 16; b++) if (!m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    // All driver tasks start and end on a falling edge.
    task automatic do_cmd(input logic [2:0] c, input logic [27:0] a,
                          output int acc_edge, output int waits);
        int n = 0;
        app_en = 1'b1; app_cmd = c; app_addr = a;
        while (app_rdy !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        waits = n;
        if (app_rdy !== 1'b1) begin
            tests++; fails++; acc_edge = -1000;
            $display("FAIL cmd_timeout: app_rdy=%b required 1", app_rdy);
        end else begin
            acc_edge = cyc + 1;
        end
        @(negedge clk);
        app_en = 1'b0;
    endtask

    task automatic do_data(input logic [127:0] d, input logic [15:0] m);
        int n = 0;
        app_wdf_data = d; app_wdf_mask = m; app_wdf_wren = 1'b1; app_wdf_end = 1'b1;
        while (app_wdf_rdy !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        if (app_wdf_rdy !== 1'b1) begin
            tests++; fails++;
            $display("FAIL wdf_timeout: app_wdf_rdy=%b required 1", app_wdf_rdy);
        end
        @(negedge clk);
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    endtask

    task automatic write_word(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
        int acc, w;
        fork
            do_data(d, m);
            do_cmd(WR, a, acc, w);
        join
        ref_mem[a[12:3]] = merge(ref_mem[a[12:3]], d, m);
    endtask

    task automatic do_read(input logic [27:0] a, output logic [127:0] d, output int lat);
        int acc, w, n;
        do_cmd(RD, a, acc, w);
        n = 0;
        while (app_rd_data_valid !== 1'b1 && n < 64) begin @(negedge clk); n++; end
        if (app_rd_data_valid === 1'b1) begin d = app_rd_data; lat = cyc - acc; end
        else begin d = 'x; lat = -1; end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0; app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_calib();
        int n = 0;
        while (init_calib_complete !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (init_calib_complete !== 1'b1) begin
            tests++; fails++;
            $display("FAIL calib_timeout: init_calib_complete=%b required 1", init_calib_complete);
        end
    endtask

    task automatic test_reset();
        int rise = -1;
        bit early = 1'b0;
        logic wdf_at_rise = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (app_rdy !== 1'b0) begin fails++; $display("FAIL rst_app_rdy: got %b want 0", app_rdy); end
        tests++; if (app_wdf_rdy !== 1'b0) begin fails++; $display("FAIL rst_wdf_rdy: got %b want 0", app_wdf_rdy); end
        tests++; if (app_rd_data !== 128'd0) begin fails++; $display("FAIL rst_rd_data: got %h want 0", app_rd_data); end
        tests++; if (app_rd_data_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", app_rd_data_valid); end
        tests++; if (init_calib_complete !== 1'b0) begin fails++; $display("FAIL rst_calib: got %b want 0", init_calib_complete); end
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL rst_error: got %b want 0", error); end
        reset_n = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (init_calib_complete === 1'b1) begin rise = i; wdf_at_rise = app_wdf_rdy; break; end
            if (app_rdy !== 1'b0 || app_wdf_rdy !== 1'b0) early = 1'b1;
        end
        tests++; if (rise != 64) begin fails++; $display("FAIL calib_cycles: got %0d want 64", rise); end
        tests++; if (early) begin fails++; $display("FAIL ready_before_calib: got 1 want 0"); end
        // Seed low nibble is 4'h1, so no write-data stall in the first calibrated cycle.
        tests++; if (wdf_at_rise !== 1'b1) begin fails++; $display("FAIL wdf_rdy_at_calib: got %b want 1", wdf_at_rise); end
    endtask

    task automatic test_basic();
        logic [127:0] d;
        int lat;
        write_word(28'h28, 128'hdeadbeefabad1deaba53b411fadebabe, 16'h0000);
        do_read(28'h28, d, lat);
        tests++; if (lat != 4) begin fails++; $display("FAIL basic_latency: got %0d want 4", lat); end
        tests++; if (d !== 128'hdeadbeefabad1deaba53b411fadebabe) begin fails++; $display("FAIL basic_data: got %h want deadbeefabad1deaba53b411fadebabe", d); end
    endtask

    task automatic test_pending();
        logic [127:0] d, wd;
        logic [27:0] a;
        int acc, w, lat;
        a = 28'($urandom_range(100, 199) * 8);
        wd = rand128();
        do_cmd(WR, a, acc, w);
        for (int k = 0; k < 3; k++) begin
            tests++; if (app_rdy !== 1'b0) begin fails++; $display("FAIL pending_rdy_%0d: got %b want 0", k, app_rdy); end
            @(negedge clk);
        end
        do_data(wd, 16'h0000);
        tests++; if (app_rdy !== 1'b0) begin fails++; $display("FAIL pending_rdy_data_edge: got %b want 0", app_rdy); end
        ref_mem[a[12:3]] = wd;
        do_read(a, d, lat);
        tests++; if (d !== wd) begin fails++; $display("FAIL pending_data: got %h want %h", d, wd); end
        tests++; if (lat != 4) begin fails++; $display("FAIL pending_latency: got %0d want 4", lat); end
    endtask

    task automatic test_mask();
        logic [127:0] d;
        logic [27:0] a;
        int lat;
        a = 28'($urandom_range(200, 299) * 8);
        write_word(a, 128'd0, 16'h0000);
        write_word(a, {128{1'b1}}, 16'hfffe);
        do_read(a, d, lat);
        tests++; if (d !== 128'hff) begin fails++; $display("FAIL mask_data: got %h want ff", d); end
    endtask

    task automatic test_random();
        logic [127:0] d;
        logic [27:0] a;
        int idx, lat;
        for (int i = 0; i < 16; i++) write_word(28'((300 + i) * 8), rand128(), 16'h0000);
        for (int i = 0; i < 40; i++) begin
            idx = $urandom_range(0, 15);
            a = 28'(($urandom & 32'h7fff) << 13) | 28'((300 + idx) * 8) | 28'($urandom_range(0, 7));
            write_word(a, rand128(), 16'($urandom));
        end
        for (int i = 0; i < 16; i++) begin
            idx = 300 + ((i * 7) % 16);
            do_read(28'(idx * 8), d, lat);
            tests++; if (d !== ref_mem[idx]) begin fails++; $display("FAIL random_data[%0d]: got %h want %h", idx, d, ref_mem[idx]); end
            tests++; if (lat != 4) begin fails++; $display("FAIL random_latency[%0d]: got %0d want 4", idx, lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] base;
        logic [127:0] exp_data_q [$];
        int exp_edge_q [$];
        int stall_waits = 0;
        int got = 0;
        int idle = 0;
        base = rand128();
        fork
            for (int i = 0; i < 1024; i++) do_data(base + 128'(i), 16'h0000);
            for (int i = 0; i < 1024; i++) begin
                int acc, w;
                do_cmd(WR, 28'(i * 8), acc, w);
            end
        join
        for (int i = 0; i < 1024; i++) ref_mem[i] = base + 128'(i);
        fork
            for (int i = 0; i < 1024; i++) begin
                int acc, w;
                do_cmd(RD, 28'(i * 8), acc, w);
                if (i > 0) stall_waits += w;
                exp_edge_q.push_back(acc + 4);
                exp_data_q.push_back(ref_mem[i]);
            end
            while (got < 1024 && idle < 200) begin
                @(negedge clk);
                if (app_rd_data_valid === 1'b1) begin
                    idle = 0;
                    tests++;
                    if (exp_data_q.size() == 0) begin
                        fails++; $display("FAIL b2b_extra_valid: got valid want none");
                    end else begin
                        logic [127:0] ed;
                        int ee;
                        ed = exp_data_q.pop_front();
                        ee = exp_edge_q.pop_front();
                        if (app_rd_data !== ed) begin fails++; $display("FAIL b2b_data[%0d]: got %h want %h", got, app_rd_data, ed); end
                        tests++;
                        if (cyc != ee) begin fails++; $display("FAIL b2b_timing[%0d]: got edge %0d want %0d", got, cyc, ee); end
                    end
                    got++;
                end else begin
                    idle++;
                end
            end
        join
        tests++; if (got != 1024) begin fails++; $display("FAIL b2b_count: got %0d want 1024", got); end
        tests++; if (stall_waits == 0) begin fails++; $display("FAIL b2b_stalls: got 0 want >0"); end
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL b2b_error: got %b want 0", error); end
    endtask

    task automatic test_bad_cmd();
        logic [127:0] d, nd;
        int acc, w, lat;
        nd = rand128();
        do_data(nd, 16'h0000);
        do_cmd(3'b010, 28'(7 * 8), acc, w);
        tests++; if (error !== 1'b1) begin fails++; $display("FAIL bad_cmd_error: got %b want 1", error); end
        do_read(28'(7 * 8), d, lat);
        tests++; if (d !== ref_mem[7]) begin fails++; $display("FAIL bad_cmd_mem: got %h want %h", d, ref_mem[7]); end
        do_cmd(WR, 28'(8 * 8), acc, w);
        ref_mem[8] = nd;
        do_read(28'(8 * 8), d, lat);
        tests++; if (d !== nd) begin fails++; $display("FAIL bad_cmd_kept_data: got %h want %h", d, nd); end
        tests++; if (error !== 1'b1) begin fails++; $display("FAIL error_sticky: got %b want 1", error); end
    endtask

    task automatic test_wdf_protocol();
        apply_reset();
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL proto_error_cleared: got %b want 0", error); end
        wait_calib();
        app_wdf_wren = 1'b1; app_wdf_end = 1'b0; app_wdf_data = rand128(); app_wdf_mask = 16'h0;
        @(negedge clk);
        app_wdf_wren = 1'b0;
        tests++; if (error !== 1'b1) begin fails++; $display("FAIL wren_no_end: got %b want 1", error); end
        apply_reset();
        wait_calib();
        app_wdf_end = 1'b1;
        @(negedge clk);
        app_wdf_end = 1'b0;
        tests++; if (error !== 1'b1) begin fails++; $display("FAIL end_no_wren: got %b want 1", error); end
    endtask

    task automatic test_reset_mid_read();
        int acc, w;
        int pulses = 0;
        apply_reset();
        wait_calib();
        do_cmd(RD, 28'h0, acc, w);
        do_cmd(RD, 28'h8, acc, w);
        #2 reset_n = 1'b0;
        #1;
        tests++; if (init_calib_complete !== 1'b0) begin fails++; $display("FAIL async_calib_clear: got %b want 0", init_calib_complete); end
        tests++; if (app_rdy !== 1'b0) begin fails++; $display("FAIL async_rdy_clear: got %b want 0", app_rdy); end
        repeat (4) begin @(negedge clk); if (app_rd_data_valid !== 1'b0) pulses++; end
        reset_n = 1'b1;
        repeat (30) begin @(negedge clk); if (app_rd_data_valid !== 1'b0) pulses++; end
        tests++; if (pulses != 0) begin fails++; $display("FAIL valid_after_reset: got %0d pulses want 0", pulses); end
        tests++; if (init_calib_complete !== 1'b0) begin fails++; $display("FAIL calib_restart: got %b want 0", init_calib_complete); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pending();
        test_mask();
        test_random();
        test_back_to_back();
        test_bad_cmd();
        test_wdf_protocol();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mig_app_responder.md
# mig_app_responder

Synthesizable stand-in for the ddr3_controller user (app) port: accepts MIG-style write and read commands from an initiator, stores 128-bit words in on-chip block RAM, and returns read data in order with a fixed latency. Pseudo-random backpressure on both ready signals exercises initiator handshake logic in simulation and on the board without DDR3 hardware. It replaces the ddr3_controller instance in memory-test builds.

## Interface
Parameters:
- ADDR_BITS, 10: word-index width; memory depth 2^ADDR_BITS × 128 bits.
- READ_LATENCY, 4: cycles from read-command acceptance to app_rd_data_valid; legal range 2..16.
- CALIB_CYCLES, 64: cycles after reset release before init_calib_complete rises.
- STALL_ENABLE, 1: 1 enables LFSR-driven ready deassertion.
- STALL_SEED, 16'hace1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- app_addr  in  28  byte address; word index = app_addr[ADDR_BITS+2:3]; other bits ignored.
- app_cmd  in  3  3'b000 write, 3'b001 read.
- app_en  in  1  command valid.
- app_rdy  out  1  command ready.
- app_wdf_data  in  128  write data.
- app_wdf_mask  in  16  per-byte mask; 1 = byte not written.
- app_wdf_wren  in  1  write data valid.
- app_wdf_end  in  1  must equal app_wdf_wren (single beat per burst).
- app_wdf_rdy  out  1  write data ready.
- app_rd_data  out  128  read data.
- app_rd_data_valid  out  1  read data strobe.
- init_calib_complete  out  1  responder ready.
- error  out  1  sticky protocol-violation flag.

## Operation
- Reset values: app_rdy 0, app_wdf_rdy 0, app_rd_data 0, app_rd_data_valid 0, init_calib_complete 0, error 0. Memory contents are not reset.
- Calibration counter counts CALIB_CYCLES after reset release, then init_calib_complete goes to 1 and stays there. Both readies are 0 until then.
- Command accepted on app_en & app_rdy. Data accepted on app_wdf_wren & app_wdf_rdy. The two ports are independent.
- Write data enters a 4-entry FIFO. app_wdf_rdy = calib & ~full & ~wdf_stall.
- Accepted write command with FIFO non-empty: pop the head and commit to memory on that edge.
- Accepted write command with FIFO empty: hold it in the pending register. app_rdy stays 0 while pending. Commit the write on the first cycle the FIFO is non-empty.
- app_rdy = calib & ~pending & ~cmd_stall.
- Commit writes bytes whose mask bit is 0.
- Accepted read enters a READ_LATENCY-deep valid/address pipeline. Memory is read synchronously in stage 1.
- Reads always follow earlier writes because commands are serialized through the pending register.
- Stall LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle after calib.
  - cmd_stall = STALL_ENABLE & lfsr[0] & lfsr[1].
  - wdf_stall = STALL_ENABLE & lfsr[2] & lfsr[3].
- Error is set and held until reset on any of:
  - accepted app_cmd other than 000/001; the command is dropped;
  - app_wdf_wren without app_wdf_end;
  - app_wdf_end without app_wdf_wren.

## Timing
- Read: command accepted at edge N → app_rd_data_valid high for one cycle after edge N+READ_LATENCY. Back-to-back reads give back-to-back valid cycles, and ordering is preserved.
- Write commit to a read of the same word: a read accepted on the cycle after the commit returns the new data.
- Pending write and data arriving in the same cycle: data is accepted at that edge and commit happens at the next edge. app_rdy rises the cycle after the commit.
- FIFO full with a simultaneous pop: app_wdf_rdy follows registered fullness, so no push is accepted that cycle.
- Reset asserted mid-operation clears the FIFO, pending register, read pipeline, LFSR and calibration counter immediately. In-flight reads are lost.

## Structure
- Shared package mig_app_pkg: CMD_WRITE, CMD_READ, APP_ADDR_W=28, APP_DATA_W=128, APP_MASK_W=16.
- Sub-module mig_wdf_fifo: 4-entry data+mask FIFO with full/empty flags.
- LFSR, pending register, read pipeline and memory live in the top level.

## Test plan
- Reset, STALL_ENABLE=0 → init_calib_complete rises exactly 64 cycles after reset release; both readies are 0 before that.
- Write word 5 = 128'hdeadbeefabad1deaba53b411fadebabe, then read addr 28'h28 → valid exactly 4 cycles after acceptance with the same data.
- Write command 3 cycles before its data → app_rdy stays 0 until commit; a following read returns the new data.
- Masked write 16'hfffe over 128'h0 with data all-ones → read returns 128'hff.
- STALL_ENABLE=1: 1024 sequential writes, then 1024 reads (data = base + index) → all match, in order, and error stays 0.
- app_cmd=3'b010 accepted → error latches 1 and memory is unchanged; asserting reset_n low mid-read-burst → no valid pulses after reset.
